// File: rtl/axi4_lite_reg_responder.sv
// rtl/axi4_lite_reg_responder.sv - AXI4-Lite register file responder
//
// Purpose:
//   AXI4-Lite slave with NUM_REGS read/write registers. Every register is
//   exported on reg_out for the user logic of the peripheral. The write and
//   read channels are independent. Each channel has one outstanding
//   transaction at a time.
//
// Configuration macro:
//   AXIL_SLVERR_EN - when defined, accesses to idx >= NUM_REGS return SLVERR
//                    (2'b10). Otherwise they return OKAY. In both builds an
//                    out-of-range write changes no register and an
//                    out-of-range read returns zero.
//
// Ports:
//   S_AXI_ACLK                 clock, rising edge
//   S_AXI_ARESET               asynchronous reset, active-high
//   S_AXI_AW* / S_AXI_W*       write address / write data channels
//   S_AXI_B*                   write response channel
//   S_AXI_AR*                  read address channel
//   S_AXI_R*                   read data channel
//   S_AXI_AWPROT, S_AXI_ARPROT accepted and ignored
//   reg_out                    register n at bits [32n+31:32n]

module axi4_lite_reg_responder #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 5,
  parameter int NUM_REGS           = 4
) (
  input  logic                                   S_AXI_ACLK,
  input  logic                                   S_AXI_ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]          S_AXI_AWADDR,
  input  logic [2:0]                             S_AXI_AWPROT,
  input  logic                                   S_AXI_AWVALID,
  output logic                                   S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]          S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]        S_AXI_WSTRB,
  input  logic                                   S_AXI_WVALID,
  output logic                                   S_AXI_WREADY,
  output logic [1:0]                             S_AXI_BRESP,
  output logic                                   S_AXI_BVALID,
  input  logic                                   S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]          S_AXI_ARADDR,
  input  logic [2:0]                             S_AXI_ARPROT,
  input  logic                                   S_AXI_ARVALID,
  output logic                                   S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]          S_AXI_RDATA,
  output logic [1:0]                             S_AXI_RRESP,
  output logic                                   S_AXI_RVALID,
  input  logic                                   S_AXI_RREADY,
  output logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] reg_out
);

  localparam int DW     = C_S_AXI_DATA_WIDTH;
  localparam int AW     = C_S_AXI_ADDR_WIDTH;
  localparam int STRB_W = DW / 8;
  localparam int IDX_W  = AW - 2;

  // One extra bit so the range compare also works when NUM_REGS == 2**IDX_W.
  localparam logic [IDX_W:0] NUM_REGS_CMP = (IDX_W + 1)'(NUM_REGS);

  localparam logic [1:0] RESP_OKAY = 2'b00;
`ifdef AXIL_SLVERR_EN
  localparam logic [1:0] RESP_OOR  = 2'b10;
`else
  localparam logic [1:0] RESP_OOR  = 2'b00;
`endif

  // ---------------------------------------------------------------------
  // Register file
  // ---------------------------------------------------------------------
  logic [DW-1:0] regs [NUM_REGS];

  // ---------------------------------------------------------------------
  // Write channel
  // ---------------------------------------------------------------------
  typedef enum logic {W_IDLE, W_RESP} w_state_t;

  w_state_t          w_state_q, w_state_d;
  logic              aw_held_q, w_held_q;
  logic [AW-1:0]     aw_addr_q;
  logic [DW-1:0]     w_data_q;
  logic [STRB_W-1:0] w_strb_q;
  logic [1:0]        bresp_q;

  logic              aw_hs, w_hs, wr_commit;
  logic [AW-1:0]     wr_addr;
  logic [DW-1:0]     wr_data;
  logic [STRB_W-1:0] wr_strb;
  logic [IDX_W-1:0]  wr_idx;
  logic              wr_in_range;

  assign aw_hs = S_AXI_AWVALID & S_AXI_AWREADY;
  assign w_hs  = S_AXI_WVALID  & S_AXI_WREADY;

  // A beat handshaken this cycle counts as held, so the commit lands on the
  // edge that completes the later of the two handshakes.
  assign wr_commit = (w_state_q == W_IDLE) & (aw_held_q | aw_hs) & (w_held_q | w_hs);

  assign wr_addr     = aw_held_q ? aw_addr_q : S_AXI_AWADDR;
  assign wr_data     = w_held_q  ? w_data_q  : S_AXI_WDATA;
  assign wr_strb     = w_held_q  ? w_strb_q  : S_AXI_WSTRB;
  assign wr_idx      = wr_addr[AW-1:2];
  assign wr_in_range = {1'b0, wr_idx} < NUM_REGS_CMP;

  // State register
  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      w_state_q <= W_IDLE;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      bresp_q   <= RESP_OKAY;
    end else begin
      w_state_q <= w_state_d;
      if (wr_commit) begin
        aw_held_q <= 1'b0;
        w_held_q  <= 1'b0;
        bresp_q   <= wr_in_range ? RESP_OKAY : RESP_OOR;
      end else begin
        if (aw_hs) begin
          aw_held_q <= 1'b1;
          aw_addr_q <= S_AXI_AWADDR;
        end
        if (w_hs) begin
          w_held_q <= 1'b1;
          w_data_q <= S_AXI_WDATA;
          w_strb_q <= S_AXI_WSTRB;
        end
      end
    end
  end

  // Next-state logic
  always_comb begin
    w_state_d = w_state_q;
    case (w_state_q)
      W_IDLE:  if (wr_commit)    w_state_d = W_RESP;
      W_RESP:  if (S_AXI_BREADY) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
  end

  // Outputs. Readies are gated by reset so they drop the moment reset asserts.
  always_comb begin
    S_AXI_AWREADY = 1'b0;
    S_AXI_WREADY  = 1'b0;
    S_AXI_BVALID  = 1'b0;
    S_AXI_BRESP   = bresp_q;
    case (w_state_q)
      W_IDLE: begin
        S_AXI_AWREADY = !S_AXI_ARESET && !aw_held_q;
        S_AXI_WREADY  = !S_AXI_ARESET && !w_held_q;
      end
      W_RESP: S_AXI_BVALID = 1'b1;
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------
  // Read channel
  // ---------------------------------------------------------------------
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  r_state_t         r_state_q, r_state_d;
  logic [DW-1:0]    rdata_q;
  logic [1:0]       rresp_q;
  logic             ar_hs;
  logic [IDX_W-1:0] rd_idx;
  logic             rd_in_range;
  logic [DW-1:0]    rd_word;

  assign ar_hs       = S_AXI_ARVALID & S_AXI_ARREADY;
  assign rd_idx      = S_AXI_ARADDR[AW-1:2];
  assign rd_in_range = {1'b0, rd_idx} < NUM_REGS_CMP;

  // Out-of-range indices match no register and read as zero.
  always_comb begin
    rd_word = '0;
    for (int n = 0; n < NUM_REGS; n++) begin
      if (rd_idx == IDX_W'(n)) rd_word = regs[n];
    end
  end

  // State register. rd_word is sampled from the pre-edge register values, so
  // a read racing a commit to the same register returns the old contents.
  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      r_state_q <= R_IDLE;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
    end else begin
      r_state_q <= r_state_d;
      if (ar_hs) begin
        rdata_q <= rd_word;
        rresp_q <= rd_in_range ? RESP_OKAY : RESP_OOR;
      end
    end
  end

  // Next-state logic
  always_comb begin
    r_state_d = r_state_q;
    case (r_state_q)
      R_IDLE:  if (ar_hs)        r_state_d = R_DATA;
      R_DATA:  if (S_AXI_RREADY) r_state_d = R_IDLE;
      default: r_state_d = R_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    S_AXI_ARREADY = 1'b0;
    S_AXI_RVALID  = 1'b0;
    S_AXI_RDATA   = rdata_q;
    S_AXI_RRESP   = rresp_q;
    case (r_state_q)
      R_IDLE:  S_AXI_ARREADY = !S_AXI_ARESET;
      R_DATA:  S_AXI_RVALID  = 1'b1;
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------
  // Register update and export
  // ---------------------------------------------------------------------
  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      for (int n = 0; n < NUM_REGS; n++) regs[n] <= '0;
    end else if (wr_commit) begin
      for (int n = 0; n < NUM_REGS; n++) begin
        if (wr_idx == IDX_W'(n)) begin
          for (int b = 0; b < STRB_W; b++) begin
            if (wr_strb[b]) regs[n][8*b +: 8] <= wr_data[8*b +: 8];
          end
        end
      end
    end
  end

  always_comb begin
    reg_out = '0;
    for (int n = 0; n < NUM_REGS; n++) reg_out[n*DW +: DW] = regs[n];
  end

  // Protection bits and byte-offset address bits carry no meaning here.
  logic unused_ok;
  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, wr_addr[1:0], S_AXI_ARADDR[1:0]};

endmodule

// File: tb/tb_axi4_lite_reg_responder.sv
// tb/tb_axi4_lite_reg_responder.sv - directed scoreboard bench for axi4_lite_reg_responder

module tb_axi4_lite_reg_responder;

`ifdef AXIL_SLVERR_EN
  localparam logic [1:0] RESP_OOR = 2'b10;
`else
  localparam logic [1:0] RESP_OOR = 2'b00;
`endif
  localparam logic [1:0] OKAY = 2'b00;

  logic         tb_ACLK = 1'b0;
  logic         areset;
  logic [4:0]   awaddr, araddr;
  logic [2:0]   awprot, arprot;
  logic         awvalid, awready, wvalid, wready, bvalid, bready;
  logic         arvalid, arready, rvalid, rready;
  logic [31:0]  wdata, rdata;
  logic [3:0]   wstrb;
  logic [1:0]   bresp, rresp;
  logic [127:0] reg_out;

  int n_checks = 0;
  int n_fail   = 0;

  logic [1:0]  exp_b [$];
  logic [33:0] exp_r [$];
  logic [31:0] model [4];

  always #5 tb_ACLK = ~tb_ACLK;

  axi4_lite_reg_responder #(
    .C_S_AXI_DATA_WIDTH(32),
    .C_S_AXI_ADDR_WIDTH(5),
    .NUM_REGS(4)
  ) dut (
    .S_AXI_ACLK(tb_ACLK),
    .S_AXI_ARESET(areset),
    .S_AXI_AWADDR(awaddr),
    .S_AXI_AWPROT(awprot),
    .S_AXI_AWVALID(awvalid),
    .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata),
    .S_AXI_WSTRB(wstrb),
    .S_AXI_WVALID(wvalid),
    .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp),
    .S_AXI_BVALID(bvalid),
    .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr),
    .S_AXI_ARPROT(arprot),
    .S_AXI_ARVALID(arvalid),
    .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata),
    .S_AXI_RRESP(rresp),
    .S_AXI_RVALID(rvalid),
    .S_AXI_RREADY(rready),
    .reg_out(reg_out)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge tb_ACLK);
    #1;
  endtask

  function automatic bit in_range(input logic [4:0] a);
    return a[4:2] < 3'd4;
  endfunction

  function automatic logic [127:0] model_flat();
    return {model[3], model[2], model[1], model[0]};
  endfunction

  task automatic model_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
    if (in_range(a)) begin
      for (int b = 0; b < 4; b++) begin
        if (s[b]) model[a[3:2]][8*b +: 8] = d[8*b +: 8];
      end
    end
  endtask

  // Response monitor: pops the scoreboard whenever a B or R handshake is due.
  always @(negedge tb_ACLK) begin
    if (!areset) begin
      if (bvalid && bready) begin
        chk("b_expected", exp_b.size() != 0, 1);
        if (exp_b.size() != 0) chk("bresp", bresp, exp_b.pop_front());
      end
      if (rvalid && rready) begin
        chk("r_expected", exp_r.size() != 0, 1);
        if (exp_r.size() != 0) chk("rresp_rdata", {rresp, rdata}, exp_r.pop_front());
      end
    end
  end

  // Write with independent AW/W start delays and a BREADY hold-off.
  task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                    input int aw_dly, input int w_dly, input int b_dly);
    bit aw_fire = 0;
    bit w_fire = 0;
    int cyc = 0;
    logic [1:0] er;
    er = in_range(a) ? OKAY : RESP_OOR;
    exp_b.push_back(er);
    model_write(a, d, s);
    awaddr = a;
    wdata  = d;
    wstrb  = s;
    bready = (b_dly == 0);
    while (!(aw_fire && w_fire) && cyc < 40) begin
      awvalid = !aw_fire && (cyc >= aw_dly);
      wvalid  = !w_fire && (cyc >= w_dly);
      if (awvalid && awready) aw_fire = 1;
      if (wvalid && wready) w_fire = 1;
      step();
      cyc++;
    end
    awvalid = 1'b0;
    wvalid  = 1'b0;
    chk("aw_w_handshake", {aw_fire, w_fire}, 2'b11);
    chk("b_latency", bvalid, 1'b1);
    for (int k = 0; k < b_dly; k++) begin
      chk("b_hold_valid", bvalid, 1'b1);
      chk("b_hold_resp", bresp, er);
      chk("b_hold_ready", {awready, wready}, 2'b00);
      step();
    end
    bready = 1'b1;
    step();
    chk("b_released", bvalid, 1'b0);
    bready = 1'b0;
    chk("reg_out", reg_out, model_flat());
  endtask

  task automatic rd(input logic [4:0] a, input logic [31:0] ed, input logic [1:0] er);
    bit fired = 0;
    int cyc = 0;
    exp_r.push_back({er, ed});
    araddr  = a;
    arvalid = 1'b1;
    rready  = 1'b1;
    while (!fired && cyc < 40) begin
      if (arready) fired = 1;
      step();
      cyc++;
    end
    arvalid = 1'b0;
    chk("ar_handshake", fired, 1'b1);
    chk("r_latency", rvalid, 1'b1);
    step();
    chk("r_released", rvalid, 1'b0);
    rready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    areset = 1'b1;
    awaddr = '0; awprot = '0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
    araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b0;
    for (int i = 0; i < 4; i++) model[i] = '0;

    #3;
    chk("rst_ready_low", {awready, wready, arready, bvalid, rvalid}, 5'b0);
    repeat (2) @(posedge tb_ACLK);
    #1 areset = 1'b0;
    step();
    chk("rst_ready_idle", {awready, wready, arready, bvalid, rvalid}, 5'b11100);
    chk("rst_resp_data", {bresp, rresp, rdata}, 36'h0);
    chk("rst_reg_out", reg_out, 128'h0);

    // Basic write / read-back on each register.
    wr(5'h00, 32'h0101FFFF, 4'hF, 0, 0, 0);  rd(5'h00, 32'h0101FFFF, OKAY);
    wr(5'h04, 32'hABCD0001, 4'hF, 0, 0, 0);  rd(5'h04, 32'hABCD0001, OKAY);
    wr(5'h08, 32'hDEAD0011, 4'hF, 0, 0, 0);  rd(5'h08, 32'hDEAD0011, OKAY);
    wr(5'h0C, 32'hBEEF0011, 4'hF, 0, 0, 0);  rd(5'h0C, 32'hBEEF0011, OKAY);
    chk("reg_out_all", reg_out, 128'hBEEF0011_DEAD0011_ABCD0001_0101FFFF);
    rd(5'h0B, 32'hDEAD0011, OKAY);  // byte offset ignored

    // Byte strobes.
    wr(5'h04, 32'hFFFFFFFF, 4'hF, 0, 0, 0);
    wr(5'h04, 32'h00000000, 4'b0101, 0, 0, 0);
    rd(5'h04, 32'hFF00FF00, OKAY);

    // Channel ordering with BREADY held off.
    wr(5'h00, 32'h13572468, 4'hF, 2, 0, 3);
    wr(5'h0C, 32'h0BADF00D, 4'hF, 0, 2, 3);
    rd(5'h00, 32'h13572468, OKAY);
    rd(5'h0C, 32'h0BADF00D, OKAY);

    // Out-of-range accesses.
    rd(5'h10, 32'h0, RESP_OOR);
    wr(5'h10, 32'h12345678, 4'hF, 0, 0, 0);
    chk("oor_regs_unchanged", reg_out, 128'h0BADF00D_DEAD0011_FF00FF00_13572468);
    rd(5'h1C, 32'h0, RESP_OOR);

    // Write commit and read handshake on the same edge, same register.
    exp_r.push_back({OKAY, 32'hDEAD0011});
    exp_b.push_back(OKAY);
    model_write(5'h08, 32'h11111111, 4'hF);
    awaddr = 5'h08; wdata = 32'h11111111; wstrb = 4'hF; araddr = 5'h08;
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1; bready = 1'b1; rready = 1'b1;
    chk("race_ready", {awready, wready, arready}, 3'b111);
    step();
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    chk("race_valids", {bvalid, rvalid}, 2'b11);
    step();
    chk("race_done", {bvalid, rvalid}, 2'b00);
    bready = 1'b0; rready = 1'b0;
    rd(5'h08, 32'h11111111, OKAY);

    // Reset while both responses are pending; those transactions are dropped.
    awaddr = 5'h04; wdata = 32'h5555AAAA; wstrb = 4'hF; araddr = 5'h00;
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
    step();
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    chk("pending_valids", {bvalid, rvalid}, 2'b11);
    #2 areset = 1'b1;
    #1;
    chk("midrst_handshake", {awready, wready, arready, bvalid, rvalid}, 5'b0);
    chk("midrst_reg_out", reg_out, 128'h0);
    chk("midrst_resp_data", {bresp, rresp, rdata}, 36'h0);
    for (int i = 0; i < 4; i++) model[i] = '0;
    @(posedge tb_ACLK);
    #1 areset = 1'b0;
    step();
    for (int i = 0; i < 4; i++) rd(5'(4 * i), 32'h0, OKAY);
    wr(5'h0C, 32'hCAFEF00D, 4'hF, 0, 0, 0);
    rd(5'h0C, 32'hCAFEF00D, OKAY);

    step();
    chk("b_queue_empty", exp_b.size(), 0);
    chk("r_queue_empty", exp_r.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
